// File: rtl/stim_pkg.sv
// Shared constants and types for the stimulus frame packer.
// Lane width, words per frame and the reset value of lane 0 are defined here.
package stim_pkg;

   localparam int WORD_W    = 32;
   localparam int NUM_WORDS = 3;
   localparam int IDX_W     = $clog2(NUM_WORDS);

   typedef logic [WORD_W-1:0] stim_word_t;
   typedef stim_word_t        stim_frame_t [NUM_WORDS];
   typedef logic [IDX_W-1:0]  stim_idx_t;

   localparam stim_word_t RST_W0   = 32'h0002_0000;
   localparam stim_idx_t  LAST_IDX = stim_idx_t'(NUM_WORDS - 1);

   // A word closes the frame when it fills the last lane or is marked last.
   function automatic logic closesFrame(input stim_idx_t idx, input logic last);
      return last || (idx == LAST_IDX);
   endfunction

endpackage

// File: rtl/stim_frame_asm.sv
// Assembly half of the double buffer.
// It owns the fill index, the assembly buffer and its full/padded flags.
// i_accept is the qualified word handshake.
// i_drain means the top copies the buffer to the output lanes this cycle.
module stim_frame_asm
   import stim_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        i_accept,
   input  stim_word_t  i_data,
   input  logic        i_last,
   input  logic        i_drain,
   output stim_frame_t o_frame,
   output logic        o_full,
   output logic        o_pad
);

   stim_idx_t   r_idx;
   stim_frame_t r_asm;
   logic        r_full;
   logic        r_pad;
   logic        w_close;

   assign w_close = i_accept && closesFrame(r_idx, i_last);

   // Fill index: advance on each accepted word and wrap to lane 0 once the frame closes.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_idx <= '0;
      end else if (i_accept) begin
         r_idx <= w_close ? '0 : r_idx + 1'b1;
      end
   end

   // Assembly buffer: store the word in its lane and zero the lanes above it on an early close.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < NUM_WORDS; i++) begin
            r_asm[i] <= '0;
         end
      end else if (i_accept) begin
         for (int i = 0; i < NUM_WORDS; i++) begin
            if (i == int'(r_idx)) begin
               r_asm[i] <= i_data;
            end else if (w_close && (i > int'(r_idx))) begin
               r_asm[i] <= '0;
            end
         end
      end
   end

   // Full/padded flags: set when a frame closes and clear when the top drains it.
   // A close in the same cycle as a drain keeps the buffer full with the new frame.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_full <= 1'b0;
         r_pad  <= 1'b0;
      end else if (w_close) begin
         r_full <= 1'b1;
         r_pad  <= i_last && (r_idx != LAST_IDX);
      end else if (i_drain) begin
         r_full <= 1'b0;
      end
   end

   assign o_frame = r_asm;
   assign o_full  = r_full;
   assign o_pad   = r_pad;

endmodule

// File: rtl/stim_frame_packer.sv
// Stimulus frame packer: packs NUM_WORDS stream words into held output lanes for the DUT wrapper.
// Assembly and output are double-buffered, so the next frame builds while the current one stays stable.
// Optional feature: define STIM_FRAME_CNT_EN to add the frame_cnt transfer counter output.
module stim_frame_packer
   import stim_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              s_valid,
   output logic              s_ready,
   input  logic [WORD_W-1:0] s_data,
   input  logic              s_last,
   output logic              m_valid,
   input  logic              m_ready,
   output logic [WORD_W-1:0] in_0,
   output logic [WORD_W-1:0] in_1,
   output logic [WORD_W-1:0] in_2,
   output logic              m_padded
`ifdef STIM_FRAME_CNT_EN
   ,
   output logic [31:0]       frame_cnt
`endif
);

   stim_frame_t w_asm;
   logic        w_asmFull;
   logic        w_asmPad;
   logic        w_transfer;
   logic        w_accept;

   stim_frame_t r_lanes;
   logic        r_mValid;
   logic        r_mPadded;

   // A full assembly buffer moves out whenever the output slot is empty or being consumed.
   assign w_transfer = w_asmFull && (!r_mValid || m_ready);
   assign s_ready    = !rst && (!w_asmFull || w_transfer);
   assign w_accept   = s_valid && s_ready;

   stim_frame_asm u_asm (
      .clk      (clk),
      .rst      (rst),
      .i_accept (w_accept),
      .i_data   (s_data),
      .i_last   (s_last),
      .i_drain  (w_transfer),
      .o_frame  (w_asm),
      .o_full   (w_asmFull),
      .o_pad    (w_asmPad)
   );

   // Output lanes: load only on a transfer, otherwise hold the last frame.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < NUM_WORDS; i++) begin
            r_lanes[i] <= (i == 0) ? RST_W0 : '0;
         end
      end else if (w_transfer) begin
         r_lanes <= w_asm;
      end
   end

   // Output handshake: a transfer raises m_valid; a consumed frame with nothing behind it drops it.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_mValid  <= 1'b0;
         r_mPadded <= 1'b0;
      end else if (w_transfer) begin
         r_mValid  <= 1'b1;
         r_mPadded <= w_asmPad;
      end else if (r_mValid && m_ready) begin
         r_mValid  <= 1'b0;
      end
   end

`ifdef STIM_FRAME_CNT_EN
   logic [31:0] r_frameCnt;

   // Frame counter: one count per transfer, wrapping naturally at 32 bits.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_frameCnt <= '0;
      end else if (w_transfer) begin
         r_frameCnt <= r_frameCnt + 32'd1;
      end
   end

   assign frame_cnt = r_frameCnt;
`endif

   assign m_valid  = r_mValid;
   assign m_padded = r_mPadded;
   assign in_0     = r_lanes[0];
   assign in_1     = r_lanes[1];
   assign in_2     = r_lanes[2];

endmodule

// File: tb/tb_stim_frame_packer.sv
// Directed testbench for stim_frame_packer.
// Inputs are driven on the falling edge and outputs are checked away from the rising edge.
// Build with STIM_FRAME_CNT_EN defined to also check frame_cnt.
module tb_stim_frame_packer;

   logic        clk = 1'b0;
   logic        rst;
   logic        s_valid;
   logic        s_ready;
   logic [31:0] s_data;
   logic        s_last;
   logic        m_valid;
   logic        m_ready;
   logic [31:0] in_0;
   logic [31:0] in_1;
   logic [31:0] in_2;
   logic        m_padded;
`ifdef STIM_FRAME_CNT_EN
   logic [31:0] frame_cnt;
`endif

   int vectorCount = 0;
   int missCount   = 0;

   stim_frame_packer dut (
      .clk      (clk),
      .rst      (rst),
      .s_valid  (s_valid),
      .s_ready  (s_ready),
      .s_data   (s_data),
      .s_last   (s_last),
      .m_valid  (m_valid),
      .m_ready  (m_ready),
      .in_0     (in_0),
      .in_1     (in_1),
      .in_2     (in_2),
      .m_padded (m_padded)
`ifdef STIM_FRAME_CNT_EN
      ,
      .frame_cnt(frame_cnt)
`endif
   );

   // Free-running clock, rising edges at 5, 15, 25, ...
   always #5 clk = ~clk;

   // Compare one observed value against its hand-computed expectation.
   task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
      vectorCount++;
      if (actual !== expected) begin
         missCount++;
         $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, actual, expected);
      end
   endtask

   // Offer one word, wait (bounded) for s_ready, let the rising edge take it, then drop s_valid.
   task automatic applyStimulus(input logic [31:0] data, input logic last);
      int waitCycles;
      s_valid = 1'b1;
      s_data  = data;
      s_last  = last;
      #1;
      waitCycles = 0;
      while (!s_ready && waitCycles < 50) begin
         @(negedge clk);
         #1;
         waitCycles++;
      end
      if (!s_ready) checkOutput("sReadyTimeout", 32'(s_ready), 32'd1);
      @(negedge clk);
      s_valid = 1'b0;
      s_last  = 1'b0;
   endtask

   // Stop a hung run with a visible failure.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int bubbles;
      int frames;
      int laneErrs;

      rst     = 1'b1;
      s_valid = 1'b0;
      s_data  = '0;
      s_last  = 1'b0;
      m_ready = 1'b0;

      // Reset state.
      @(negedge clk);
      #1;
      checkOutput("rstSReady", 32'(s_ready), 32'd0);
      checkOutput("rstIn0", in_0, 32'h0002_0000);
      checkOutput("rstIn1", in_1, 32'd0);
      checkOutput("rstIn2", in_2, 32'd0);
      checkOutput("rstMValid", 32'(m_valid), 32'd0);
      checkOutput("rstPadded", 32'(m_padded), 32'd0);
`ifdef STIM_FRAME_CNT_EN
      checkOutput("rstFrameCnt", frame_cnt, 32'd0);
`endif
      @(negedge clk);
      rst = 1'b0;
      #1;
      checkOutput("postRstSReady", 32'(s_ready), 32'd1);

      // Full frame back-to-back; m_valid arrives one edge after the last word.
      m_ready = 1'b1;
      applyStimulus(32'h11, 1'b0);
      applyStimulus(32'h22, 1'b0);
      applyStimulus(32'h33, 1'b0);
      #1;
      checkOutput("latEdgeN", 32'(m_valid), 32'd0);
      @(negedge clk);
      checkOutput("f1MValid", 32'(m_valid), 32'd1);
      checkOutput("f1In0", in_0, 32'h11);
      checkOutput("f1In1", in_1, 32'h22);
      checkOutput("f1In2", in_2, 32'h33);
      checkOutput("f1Padded", 32'(m_padded), 32'd0);
      @(negedge clk);
      checkOutput("f1Consumed", 32'(m_valid), 32'd0);
      checkOutput("f1HoldIn0", in_0, 32'h11);

      // Short frame closed by s_last; the unused lane reads zero.
      applyStimulus(32'hAA, 1'b0);
      applyStimulus(32'hBB, 1'b1);
      @(negedge clk);
      checkOutput("padMValid", 32'(m_valid), 32'd1);
      checkOutput("padIn0", in_0, 32'hAA);
      checkOutput("padIn1", in_1, 32'hBB);
      checkOutput("padIn2", in_2, 32'd0);
      checkOutput("padPadded", 32'(m_padded), 32'd1);
      @(negedge clk);

      // Back-pressure: two frames queued, the first held stable, input stalled.
      m_ready = 1'b0;
      for (int i = 1; i <= 6; i++) applyStimulus(32'h100 + 32'(i), 1'b0);
      #1;
      checkOutput("bpSReady", 32'(s_ready), 32'd0);
      checkOutput("bpMValid", 32'(m_valid), 32'd1);
      checkOutput("bpIn0", in_0, 32'h101);
      checkOutput("bpIn1", in_1, 32'h102);
      checkOutput("bpIn2", in_2, 32'h103);
      repeat (3) @(negedge clk);
      #1;
      checkOutput("bpHoldIn0", in_0, 32'h101);
      checkOutput("bpHoldIn2", in_2, 32'h103);
      checkOutput("bpHoldSReady", 32'(s_ready), 32'd0);
      m_ready = 1'b1;
      #1;
      checkOutput("bpReleaseSReady", 32'(s_ready), 32'd1);
      @(negedge clk);
      checkOutput("bpF2MValid", 32'(m_valid), 32'd1);
      checkOutput("bpF2In0", in_0, 32'h104);
      checkOutput("bpF2In1", in_1, 32'h105);
      checkOutput("bpF2In2", in_2, 32'h106);
      @(negedge clk);
      checkOutput("bpF2Consumed", 32'(m_valid), 32'd0);

      // s_last landing on the final lane is an ordinary full frame.
      applyStimulus(32'h1, 1'b0);
      applyStimulus(32'h2, 1'b0);
      applyStimulus(32'h3, 1'b1);
      @(negedge clk);
      checkOutput("lastFullIn2", in_2, 32'h3);
      checkOutput("lastFullPadded", 32'(m_padded), 32'd0);

      // A single word with s_last pads both upper lanes.
      applyStimulus(32'hC0, 1'b1);
      @(negedge clk);
      checkOutput("singleIn0", in_0, 32'hC0);
      checkOutput("singleIn1", in_1, 32'd0);
      checkOutput("singleIn2", in_2, 32'd0);
      checkOutput("singlePadded", 32'(m_padded), 32'd1);
      @(negedge clk);

      // Fresh reset, then 300 continuous words with m_ready held high.
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      bubbles  = 0;
      frames   = 0;
      laneErrs = 0;
      for (int i = 0; i < 300; i++) begin
         s_valid = 1'b1;
         s_data  = 32'(i);
         s_last  = 1'b0;
         #1;
         if (!s_ready) bubbles++;
         if (m_valid) begin
            if (in_0 !== 32'(3 * frames))     laneErrs++;
            if (in_1 !== 32'(3 * frames + 1)) laneErrs++;
            if (in_2 !== 32'(3 * frames + 2)) laneErrs++;
            frames++;
         end
         @(negedge clk);
      end
      for (int t = 0; t < 4; t++) begin
         s_valid = 1'b0;
         #1;
         if (m_valid) begin
            if (in_0 !== 32'(3 * frames))     laneErrs++;
            if (in_1 !== 32'(3 * frames + 1)) laneErrs++;
            if (in_2 !== 32'(3 * frames + 2)) laneErrs++;
            frames++;
         end
         @(negedge clk);
      end
      checkOutput("streamBubbles", 32'(bubbles), 32'd0);
      checkOutput("streamFrames", 32'(frames), 32'd100);
      checkOutput("streamLaneErrs", 32'(laneErrs), 32'd0);
      checkOutput("streamLastIn2", in_2, 32'd299);
`ifdef STIM_FRAME_CNT_EN
      checkOutput("streamFrameCnt", frame_cnt, 32'd100);
`endif

      // Reset in the middle of a frame discards it and restores the lanes.
      applyStimulus(32'h55, 1'b0);
      applyStimulus(32'h66, 1'b0);
      rst = 1'b1;
      #1;
      checkOutput("midRstSReady", 32'(s_ready), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      #1;
      checkOutput("midRstIn0", in_0, 32'h0002_0000);
      checkOutput("midRstIn1", in_1, 32'd0);
      checkOutput("midRstIn2", in_2, 32'd0);
      checkOutput("midRstMValid", 32'(m_valid), 32'd0);
      applyStimulus(32'h77, 1'b0);
      applyStimulus(32'h88, 1'b0);
      applyStimulus(32'h99, 1'b0);
      @(negedge clk);
      checkOutput("freshMValid", 32'(m_valid), 32'd1);
      checkOutput("freshIn0", in_0, 32'h77);
      checkOutput("freshIn1", in_1, 32'h88);
      checkOutput("freshIn2", in_2, 32'h99);
      checkOutput("freshPadded", 32'(m_padded), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
      $finish;
   end

endmodule
